// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 compression sequencer and its helpers.
package sha_pkg;

  localparam int SHA_ADDR_WTH   = 6;   // ROM address / round index width
  localparam int SHA_NUM_ROUNDS = 64;  // rounds per 512-bit block
  localparam int SHA_MSG_WORDS  = 16;  // rounds fed straight from the message block

  // Phases of one compression pass.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sha_round_counter.sv
// Modulo-MAX_COUNT round counter with enable, synchronous clear and a
// terminal-count flag. Also used by the message scheduler.
module sha_round_counter #(
  parameter int WIDTH     = 6,
  parameter int MAX_COUNT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_COUNT - 1);

  // Terminal count: the counter sits on its last value.
  assign tc = (count == LAST);

  // Count register: clear wins over enable; wraps to zero after the last value.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequencer for one SHA-256 compression pass: drives the round-constant ROM
// one entry ahead of the datapath and issues init/round/final/done strobes.
module sha256_round_ctrl
  import sha_pkg::*;
#(
  parameter int ADDR_WTH   = SHA_ADDR_WTH,
  parameter int NUM_ROUNDS = SHA_NUM_ROUNDS,  // must not exceed 2**ADDR_WTH
  parameter int MSG_WORDS  = SHA_MSG_WORDS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_stall,
  input  logic                i_abort,
  output logic                o_busy,
  output logic                o_rc_enable,
  output logic [ADDR_WTH-1:0] o_rc_add,
  output logic                o_init_load,
  output logic                o_round_valid,
  output logic [ADDR_WTH-1:0] o_round_idx,
  output logic                o_w_sel,
  output logic                o_final_add,
  output logic                o_done
);

  localparam logic [ADDR_WTH-1:0] FIRST_SCHED = ADDR_WTH'(MSG_WORDS);

  state_e              state;
  state_e              state_nxt;
  logic [ADDR_WTH-1:0] k;
  logic                k_last;
  logic                in_round;
  logic                advance;

  assign in_round = (state == ST_ROUND);
  // A round is consumed only when the datapath is not stalled.
  assign advance  = in_round && !i_stall;

  // Round index k: counts consumed rounds, forced to zero outside ROUND and on
  // abort so every block starts from round 0.
  sha_round_counter #(
    .WIDTH    (ADDR_WTH),
    .MAX_COUNT(NUM_ROUNDS)
  ) u_round_counter (
    .clk  (clk),
    .reset(reset),
    .en   (advance),
    .clr  (i_abort || !in_round),
    .count(k),
    .tc   (k_last)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides both stall and the normal transition.
  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (i_start) state_nxt = ST_INIT;
      ST_INIT:  state_nxt = ST_ROUND;
      ST_ROUND: if (advance && k_last) state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (state != ST_IDLE && i_abort) begin
      state_nxt = ST_IDLE;
    end
  end

  // Output decode from registered state and k; only the ROM enable and the
  // round strobe see i_stall directly.
  always_comb begin
    o_busy        = (state != ST_IDLE);
    o_rc_enable   = 1'b0;
    o_rc_add      = '0;
    o_init_load   = 1'b0;
    o_round_valid = 1'b0;
    o_round_idx   = '0;
    o_w_sel       = 1'b0;
    o_final_add   = 1'b0;
    o_done        = 1'b0;
    unique case (state)
      ST_INIT: begin
        // Prefetch K[0] so it is on the ROM output during round 0.
        o_init_load = 1'b1;
        o_rc_enable = 1'b1;
      end
      ST_ROUND: begin
        o_round_valid = !i_stall;
        o_round_idx   = k;
        o_w_sel       = (k >= FIRST_SCHED);
        // Fetch K[k+1]; on the last round the address parks at k, ROM idle.
        o_rc_add      = k_last ? k : k + 1'b1;
        o_rc_enable   = !i_stall && !k_last;
      end
      ST_FINAL: o_final_add = 1'b1;
      ST_DONE:  o_done      = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: directed scenarios plus random
// start/stall/abort traffic against a timeline model of one block.
module tb_sha256_round_ctrl;

  logic       clk;
  logic       reset;
  logic       i_start, i_stall, i_abort;
  logic       o_busy, o_rc_enable, o_init_load, o_round_valid;
  logic       o_w_sel, o_final_add, o_done;
  logic [5:0] o_rc_add, o_round_idx;

  sha256_round_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_stall      (i_stall),
    .i_abort      (i_abort),
    .o_busy       (o_busy),
    .o_rc_enable  (o_rc_enable),
    .o_rc_add     (o_rc_add),
    .o_init_load  (o_init_load),
    .o_round_valid(o_round_valid),
    .o_round_idx  (o_round_idx),
    .o_w_sel      (o_w_sel),
    .o_final_add  (o_final_add),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-constant table and a registered-read ROM with hold on enable low.
  logic [31:0] k_tab [64];
  logic [31:0] rom_q;
  initial begin
    k_tab = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  end
  always @(posedge clk) if (o_rc_enable) rom_q <= k_tab[o_rc_add];

  logic [18:0] dut_vec;
  assign dut_vec = {o_busy, o_rc_enable, o_rc_add, o_init_load, o_round_valid,
                    o_round_idx, o_w_sel, o_final_add, o_done};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: position in the block timeline. -1 idle, 0 init, 1..64 round
  // pos-1, 65 final add, 66 done.
  int pos = -1;
  int cyc = 0;

  function automatic logic [18:0] expect_vec(input int p, input bit st);
    bit       busy, en, init, valid, wsel, fin, done;
    bit [5:0] add, idx;
    int       r;
    bit       rnd;
    r     = p - 1;
    rnd   = (p >= 1) && (p <= 64);
    busy  = (p >= 0);
    init  = (p == 0);
    valid = rnd && !st;
    idx   = rnd ? 6'(r) : 6'd0;
    wsel  = rnd && (r >= 16);
    add   = rnd ? ((r < 63) ? 6'(r + 1) : 6'd63) : 6'd0;
    en    = init || (rnd && !st && (r < 63));
    fin   = (p == 65);
    done  = (p == 66);
    return {busy, en, add, init, valid, idx, wsel, fin, done};
  endfunction

  // Trackers for cycle-accurate directed checks.
  int init_cyc, final_cyc, done_cyc, valid_cnt, init_cnt, final_cnt, done_cnt, max_add;
  logic [31:0] rom_at0, rom_at63;

  task automatic clear_trk();
    init_cyc = -1; final_cyc = -1; done_cyc = -1;
    valid_cnt = 0; init_cnt = 0; final_cnt = 0; done_cnt = 0; max_add = 0;
    rom_at0 = '0; rom_at63 = '0;
  endtask

  // One clock: drive inputs at the falling edge, compare just after, then
  // advance the model to what the next rising edge should produce.
  task automatic tick(input bit s, input bit st, input bit ab);
    @(negedge clk);
    i_start = s; i_stall = st; i_abort = ab;
    #1;
    cyc++;
    check("outs", 64'(dut_vec), 64'(expect_vec(pos, st)));
    if (pos >= 1 && pos <= 64) check("rom", 64'(rom_q), 64'(k_tab[pos-1]));
    if (o_init_load)   begin init_cyc = cyc; init_cnt++; end
    if (o_final_add)   begin final_cyc = cyc; final_cnt++; end
    if (o_done)        begin done_cyc = cyc; done_cnt++; end
    if (o_round_valid) begin
      valid_cnt++;
      if (o_round_idx == 6'd0)  rom_at0  = rom_q;
      if (o_round_idx == 6'd63) rom_at63 = rom_q;
    end
    if (int'(o_rc_add) > max_add) max_add = int'(o_rc_add);
    if (pos < 0) begin
      if (s) pos = 0;
    end else if (ab) begin
      pos = -1;
    end else if (!(pos >= 1 && pos <= 64 && st)) begin
      pos = (pos == 66) ? -1 : pos + 1;
    end
  endtask

  int t0;

  initial begin
    reset = 1'b1; i_start = 1'b0; i_stall = 1'b0; i_abort = 1'b0;
    #1;
    check("reset_outs", 64'(dut_vec), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick(0, 0, 0);
    tick(0, 0, 0);

    // Single block, no stall.
    tick(1, 0, 0); t0 = cyc; clear_trk();
    for (int c = 1; c <= 68; c++) tick(0, 0, 0);
    check("blk_init_cyc",  64'(init_cyc - t0), 64'd1);
    check("blk_final_cyc", 64'(final_cyc - t0), 64'd66);
    check("blk_done_cyc",  64'(done_cyc - t0), 64'd67);
    check("blk_valid_cnt", 64'(valid_cnt), 64'd64);
    check("blk_rom_k0",    64'(rom_at0), 64'h428a2f98);
    check("blk_rom_k63",   64'(rom_at63), 64'hc67178f2);
    check("blk_max_add",   64'(max_add), 64'd63);

    // Three stall cycles while round 10 is current (cycles 12..14).
    tick(1, 0, 0); t0 = cyc; clear_trk();
    for (int c = 1; c <= 71; c++) tick(0, (c >= 12 && c <= 14), 0);
    check("stall_done_cyc",  64'(done_cyc - t0), 64'd70);
    check("stall_valid_cnt", 64'(valid_cnt), 64'd64);

    // Starts in ROUND and DONE ignored; start in IDLE cycle 68 accepted.
    tick(1, 0, 0); t0 = cyc; clear_trk();
    for (int c = 1; c <= 136; c++) tick((c == 20 || c == 67 || c == 68), 0, 0);
    check("b2b_init_cnt",  64'(init_cnt), 64'd2);
    check("b2b_init2_cyc", 64'(init_cyc - t0), 64'd69);
    check("b2b_done_cnt",  64'(done_cnt), 64'd2);
    check("b2b_done2_cyc", 64'(done_cyc - t0), 64'd135);

    // Abort while round 40 is current (cycle 42).
    tick(1, 0, 0); t0 = cyc; clear_trk();
    for (int c = 1; c <= 70; c++) tick(0, 0, (c == 42));
    check("abort_final_cnt", 64'(final_cnt), 64'd0);
    check("abort_done_cnt",  64'(done_cnt), 64'd0);
    check("abort_valid_cnt", 64'(valid_cnt), 64'd41);

    // Asynchronous reset while round 20 is current, then a clean restart.
    tick(1, 0, 0);
    for (int c = 1; c <= 22; c++) tick(0, 0, 0);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_outs", 64'(dut_vec), 64'd0);
    check("rst_mid_busy", 64'(o_busy), 64'd0);
    pos = -1;
    @(negedge clk);
    reset = 1'b0;
    tick(1, 0, 0); t0 = cyc; clear_trk();
    for (int c = 1; c <= 68; c++) tick(0, 0, 0);
    check("rst_restart_done", 64'(done_cyc - t0), 64'd67);
    check("rst_restart_rom0", 64'(rom_at0), 64'h428a2f98);

    // Random traffic.
    for (int c = 0; c < 3000; c++)
      tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 149) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
